// File: rtl/adam_obi_arbiter.sv
// adam_obi_arbiter
// Two-requester OBI arbiter (0 = instruction port, 1 = data port) feeding a
// single OBI master toward the AXI-Lite bridge. Round-robin address phase
// with OBI no-retract locking, an in-order ID FIFO to return responses to
// the right requester, and a pause handshake that drains in-flight traffic.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   pause_req_i/pause_ack_o  pause handshake (ack high only once drained)
//   s_req_i/s_gnt_o          per-requester address-phase handshake
//   s_addr_i/s_we_i/s_be_i/s_wdata_i  per-requester request attributes
//   s_rvalid_o/s_rready_i/s_rdata_o   per-requester response phase
//   m_req_o/m_gnt_i          shared address phase
//   m_addr_o/m_we_o/m_be_o/m_wdata_o  muxed request attributes
//   m_rvalid_i/m_rready_o/m_rdata_i   shared response phase
module adam_obi_arbiter #(
  parameter  int ADDR_WIDTH      = 32,
  parameter  int DATA_WIDTH      = 32,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int STRB_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 pause_req_i,
  output logic                                 pause_ack_o,
  input  logic [1:0]                           s_req_i,
  output logic [1:0]                           s_gnt_o,
  input  logic [1:0][ADDR_WIDTH-1:0]           s_addr_i,
  input  logic [1:0]                           s_we_i,
  input  logic [1:0][STRB_WIDTH-1:0]           s_be_i,
  input  logic [1:0][DATA_WIDTH-1:0]           s_wdata_i,
  output logic [1:0]                           s_rvalid_o,
  input  logic [1:0]                           s_rready_i,
  output logic [1:0][DATA_WIDTH-1:0]           s_rdata_o,
  output logic                                 m_req_o,
  input  logic                                 m_gnt_i,
  output logic [ADDR_WIDTH-1:0]                m_addr_o,
  output logic                                 m_we_o,
  output logic [STRB_WIDTH-1:0]                m_be_o,
  output logic [DATA_WIDTH-1:0]                m_wdata_o,
  input  logic                                 m_rvalid_i,
  output logic                                 m_rready_o,
  input  logic [DATA_WIDTH-1:0]                m_rdata_i
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_e;

  state_e                     state_q;
  logic                       prio_q, lock_q, lock_idx_q, post_rst_q;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic                       sel, issue_ok, hs, empty, head, pop, lock_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    // A stalled request keeps its slot until granted, so sel must not move.
    if (lock_q)          sel = lock_idx_q;
    else if (&s_req_i)   sel = prio_q;
    else                 sel = s_req_i[1];
    issue_ok = (count_q < CNT_W'(MAX_OUTSTANDING)) && (state_q == RUN);
    // Once presented, a request cannot be withdrawn by pause or a full FIFO.
    m_req_o  = s_req_i[sel] && (lock_q || issue_ok);
    hs       = m_req_o && m_gnt_i;
    s_gnt_o      = '0;
    s_gnt_o[sel] = hs;
    m_addr_o  = s_addr_i[sel];
    m_we_o    = s_we_i[sel];
    m_be_o    = s_be_i[sel];
    m_wdata_o = s_wdata_i[sel];

    empty      = (count_q == '0);
    head       = fifo_q[rd_ptr_q];
    // With nothing outstanding, stray responses are sunk rather than stalled.
    m_rready_o = empty ? 1'b1 : s_rready_i[head];
    s_rvalid_o = '0;
    s_rdata_o  = '0;
    if (!empty) begin
      s_rvalid_o[head] = m_rvalid_i;
      s_rdata_o[head]  = m_rdata_i;
    end
    pop = m_rvalid_i && m_rready_o && !empty;

    count_d = count_q;
    if (hs && !pop)      count_d = count_q + CNT_W'(1);
    else if (!hs && pop) count_d = count_q - CNT_W'(1);
    lock_d = lock_q;
    if (hs)           lock_d = 1'b0;
    else if (m_req_o) lock_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    post_rst_q <= rst_i;
    if (rst_i) begin
      state_q     <= RUN;
      pause_ack_o <= 1'b0;
      prio_q      <= 1'b0;
      lock_q      <= 1'b0;
      lock_idx_q  <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_q      <= '0;
    end else begin
      count_q    <= count_d;
      lock_q     <= lock_d;
      lock_idx_q <= sel;  // only consulted while locked, when sel already equals it
      if (hs) begin
        prio_q           <= ~sel;
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      // Drained test uses next-state so ack rises right after the last response.
      case (state_q)
        RUN:    if (pause_req_i) state_q <= DRAIN;
        DRAIN:
          if (!pause_req_i) state_q <= RUN;
          else if (count_d == '0 && !lock_d) begin
            state_q     <= PAUSED;
            pause_ack_o <= 1'b1;
          end
        PAUSED:
          if (!pause_req_i) begin
            state_q     <= RUN;
            pause_ack_o <= 1'b0;
          end
        default: state_q <= RUN;
      endcase
    end
  end

  // Responses straggling in right after reset belong to discarded traffic.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !post_rst_q)
      assert (!(m_rvalid_i && empty))
        else $error("adam_obi_arbiter: response with no outstanding transaction");
  end

endmodule
